// File: rtl/mem_stage_if.sv
//------------------------------------------------------------------------------
// Module  : mem_stage_if
// Purpose : Bundles the EX/MEM inputs, data-memory port and MEM/WB outputs
//           of the memory-access stage.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_stage_if #(
  parameter int WbSize = 4,
  parameter int ADDR_W = 12
);
  // EX/MEM side
  logic              i_valid;
  logic              i_MemRead;
  logic              i_MemWrite;
  logic              i_Word32;
  logic [1:0]        i_StackOp;
  logic [15:0]       i_Addr;
  logic [31:0]       i_WrData;
  logic [WbSize-1:0] i_WB;
  logic [15:0]       i_alu;
  logic [2:0]        i_Rdst;
  // data-memory side
  logic [ADDR_W-1:0] o_DmAddr;
  logic              o_DmWrEn;
  logic [15:0]       o_DmWrData;
  logic [15:0]       i_DmRdData;
  // hazard / status
  logic              o_Stall;
  logic [ADDR_W-1:0] o_SP;
  // MEM/WB side
  logic [WbSize-1:0] o_WB;
  logic [31:0]       o_MemData;
  logic [15:0]       o_alu;
  logic [2:0]        o_Rdst;

  // Stage view: consumes i_* and produces o_*
  modport slave (
    input  i_valid, i_MemRead, i_MemWrite, i_Word32, i_StackOp, i_Addr,
           i_WrData, i_WB, i_alu, i_Rdst, i_DmRdData,
    output o_DmAddr, o_DmWrEn, o_DmWrData, o_Stall, o_SP, o_WB,
           o_MemData, o_alu, o_Rdst
  );

  // Environment view: pipeline + memory surrounding the stage
  modport master (
    output i_valid, i_MemRead, i_MemWrite, i_Word32, i_StackOp, i_Addr,
           i_WrData, i_WB, i_alu, i_Rdst, i_DmRdData,
    input  o_DmAddr, o_DmWrEn, o_DmWrData, o_Stall, o_SP, o_WB,
           o_MemData, o_alu, o_Rdst
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage.sv
//------------------------------------------------------------------------------
// Module  : mem_stage
// Purpose : Memory-access pipeline stage. Drives a 16-bit data memory, owns
//           the stack pointer, and splits 32-bit accesses into two cycles
//           (word A in IDLE with an upstream stall, word B in SECOND).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_stage #(
  parameter int              WbSize   = 4,
  parameter int              ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_SECOND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       lo_q, lo_d;       // low half captured during word A of a 32-bit read
  logic              push_q, push_d;   // operation kind held across word B
  logic              pop_q, pop_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;

  logic              is_push, is_pop, wr_req, rd_req;
  logic [ADDR_W-1:0] addr_in, addr_in_p1;
  logic [ADDR_W-1:0] sp_p1, sp_p2, sp_m1, sp_m2;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_we;
  logic [15:0]       dm_wdata;
  logic [31:0]       mem_data;
  logic              stall;
  logic              wb_pass;
  logic [WbSize-1:0] wb_out;
  logic              unused_addr_hi;

  assign unused_addr_hi = &{1'b0, bus.i_Addr[15:ADDR_W]};

  // Decode the incoming request; a stack op overrides the plain load/store
  // flags and a write beats a simultaneous read.
  always_comb begin
    is_push    = (bus.i_StackOp == 2'b01);
    is_pop     = (bus.i_StackOp == 2'b10);
    wr_req     = is_push | (~is_push & ~is_pop & bus.i_MemWrite);
    rd_req     = is_pop  | (~is_push & ~is_pop & bus.i_MemRead & ~bus.i_MemWrite);
    addr_in    = bus.i_Addr[ADDR_W-1:0];
    addr_in_p1 = addr_in + ADDR_W'(1);
    sp_p1      = sp_q + ADDR_W'(1);
    sp_p2      = sp_q + ADDR_W'(2);
    sp_m1      = sp_q - ADDR_W'(1);
    sp_m2      = sp_q - ADDR_W'(2);
  end

  // Next-state, SP update and all memory/writeback outputs.
  always_comb begin
    state_d  = state_q;
    sp_d     = sp_q;
    lo_d     = lo_q;
    push_d   = push_q;
    pop_d    = pop_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    dm_addr  = '0;
    dm_we    = 1'b0;
    dm_wdata = '0;
    mem_data = '0;
    stall    = 1'b0;
    wb_pass  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          wb_pass = 1'b1;
          if (wr_req || rd_req) begin
            dm_we = wr_req;
            if (is_push)     dm_addr = sp_q;
            else if (is_pop) dm_addr = sp_p1;
            else             dm_addr = addr_in;

            if (bus.i_Word32) begin
              // Word A: push writes the high half first, everything else the low half
              dm_wdata = is_push ? bus.i_WrData[31:16] : bus.i_WrData[15:0];
              stall    = 1'b1;
              wb_pass  = 1'b0;
              state_d  = S_SECOND;
              if (rd_req) lo_d = bus.i_DmRdData;
              push_d   = is_push;
              pop_d    = is_pop;
              wr_d     = wr_req;
              rd_d     = rd_req;
            end else begin
              dm_wdata = bus.i_WrData[15:0];
              if (rd_req)  mem_data = {16'h0000, bus.i_DmRdData};
              if (is_push) sp_d = sp_m1;
              if (is_pop)  sp_d = sp_p1;
            end
          end
        end
      end

      S_SECOND: begin
        // Word B completes regardless of i_valid; upstream is holding its inputs.
        wb_pass = 1'b1;
        state_d = S_IDLE;
        dm_we   = wr_q;
        if (push_q)     dm_addr = sp_m1;
        else if (pop_q) dm_addr = sp_p2;
        else            dm_addr = addr_in_p1;
        dm_wdata = push_q ? bus.i_WrData[15:0] : bus.i_WrData[31:16];
        if (rd_q)   mem_data = {bus.i_DmRdData, lo_q};
        if (push_q) sp_d = sp_m2;
        if (pop_q)  sp_d = sp_p2;
      end

      default: state_d = S_IDLE;
    endcase

    // Reset must quiet the pipeline immediately, even mid-operation.
    if (rst) begin
      stall   = 1'b0;
      dm_we   = 1'b0;
      wb_pass = 1'b0;
    end
  end

  // State, SP, low-half latch and held operation kind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sp_q    <= SP_RESET;
      lo_q    <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      lo_q    <= lo_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  assign wb_out         = wb_pass ? bus.i_WB : '0;
  assign bus.o_WB       = wb_out;
  assign bus.o_DmAddr   = dm_addr;
  assign bus.o_DmWrEn   = dm_we;
  assign bus.o_DmWrData = dm_wdata;
  assign bus.o_Stall    = stall;
  assign bus.o_SP       = sp_q;
  assign bus.o_MemData  = mem_data;
  assign bus.o_alu      = bus.i_alu;
  assign bus.o_Rdst     = bus.i_Rdst;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_stage
// Purpose : Directed self-checking bench for mem_stage with a 4K x 16 memory.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  logic [15:0] mem [0:4095];

  always #5 clk = ~clk;

  mem_stage_if #(.WbSize(4), .ADDR_W(12)) bus ();

  mem_stage #(.WbSize(4), .ADDR_W(12), .SP_RESET(12'hFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: combinational read, synchronous write
  always_comb bus.i_DmRdData = mem[bus.o_DmAddr];
  always @(posedge clk) if (bus.o_DmWrEn) mem[bus.o_DmAddr] <= bus.o_DmWrData;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.i_valid = 0; bus.i_MemRead = 0; bus.i_MemWrite = 0; bus.i_Word32 = 0;
    bus.i_StackOp = 2'b00; bus.i_Addr = 16'h0; bus.i_WrData = 32'h0;
    bus.i_WB = 4'h0; bus.i_alu = 16'h0; bus.i_Rdst = 3'h0;
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic w32, input logic [1:0] sop,
                    input logic [15:0] a, input logic [31:0] d, input logic [3:0] wb);
    bus.i_valid = 1; bus.i_MemRead = rd; bus.i_MemWrite = wr; bus.i_Word32 = w32;
    bus.i_StackOp = sop; bus.i_Addr = a; bus.i_WrData = d; bus.i_WB = wb;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    idle();
    // reset with a live-looking store on the inputs
    op(1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 32'h0000FFFF, 4'hF);
    @(negedge clk);
    chk("rst_stall", {31'b0, bus.o_Stall}, 32'd0);
    chk("rst_wren",  {31'b0, bus.o_DmWrEn}, 32'd0);
    chk("rst_wb",    {28'b0, bus.o_WB}, 32'd0);
    chk("rst_sp",    {20'b0, bus.o_SP}, 32'h0FFF);
    next(); rst = 1'b0; idle();
    next();

    // 16-bit store then load
    op(1'b0, 1'b1, 1'b0, 2'b00, 16'h0010, 32'h00001234, 4'h5);
    bus.i_alu = 16'hBEEF; bus.i_Rdst = 3'd3;
    @(negedge clk);
    chk("st16_wren",  {31'b0, bus.o_DmWrEn}, 32'd1);
    chk("st16_addr",  {20'b0, bus.o_DmAddr}, 32'h010);
    chk("st16_wdata", {16'b0, bus.o_DmWrData}, 32'h1234);
    chk("st16_stall", {31'b0, bus.o_Stall}, 32'd0);
    chk("st16_wb",    {28'b0, bus.o_WB}, 32'h5);
    chk("alu_pass",   {16'b0, bus.o_alu}, 32'hBEEF);
    chk("rdst_pass",  {29'b0, bus.o_Rdst}, 32'd3);
    next();
    op(1'b1, 1'b0, 1'b0, 2'b00, 16'h0010, 32'h0, 4'h5);
    @(negedge clk);
    chk("ld16_data",  bus.o_MemData, 32'h00001234);
    chk("ld16_stall", {31'b0, bus.o_Stall}, 32'd0);
    chk("ld16_wren",  {31'b0, bus.o_DmWrEn}, 32'd0);
    next();

    // read+write conflict: write wins, no read data
    op(1'b1, 1'b1, 1'b0, 2'b00, 16'h0011, 32'h00005555, 4'h2);
    @(negedge clk);
    chk("rw_wren", {31'b0, bus.o_DmWrEn}, 32'd1);
    chk("rw_data", bus.o_MemData, 32'h0);
    next();

    // push32 0xDEADBEEF from SP=FFF
    op(1'b0, 1'b0, 1'b1, 2'b01, 16'h0, 32'hDEADBEEF, 4'hA);
    @(negedge clk);
    chk("push32A_stall", {31'b0, bus.o_Stall}, 32'd1);
    chk("push32A_wb",    {28'b0, bus.o_WB}, 32'h0);
    chk("push32A_addr",  {20'b0, bus.o_DmAddr}, 32'hFFF);
    chk("push32A_wdata", {16'b0, bus.o_DmWrData}, 32'hDEAD);
    next();
    @(negedge clk);
    chk("push32B_stall", {31'b0, bus.o_Stall}, 32'd0);
    chk("push32B_wb",    {28'b0, bus.o_WB}, 32'hA);
    chk("push32B_addr",  {20'b0, bus.o_DmAddr}, 32'hFFE);
    chk("push32B_wdata", {16'b0, bus.o_DmWrData}, 32'hBEEF);
    next(); idle();
    chk("push32_sp",    {20'b0, bus.o_SP}, 32'hFFD);
    chk("push32_memhi", {16'b0, mem[12'hFFF]}, 32'hDEAD);
    chk("push32_memlo", {16'b0, mem[12'hFFE]}, 32'hBEEF);

    // pop32 back
    op(1'b0, 1'b0, 1'b1, 2'b10, 16'h0, 32'h0, 4'h6);
    @(negedge clk);
    chk("pop32A_stall", {31'b0, bus.o_Stall}, 32'd1);
    chk("pop32A_addr",  {20'b0, bus.o_DmAddr}, 32'hFFE);
    next();
    @(negedge clk);
    chk("pop32B_addr", {20'b0, bus.o_DmAddr}, 32'hFFF);
    chk("pop32B_data", bus.o_MemData, 32'hDEADBEEF);
    chk("pop32B_wb",   {28'b0, bus.o_WB}, 32'h6);
    next(); idle();
    chk("pop32_sp", {20'b0, bus.o_SP}, 32'hFFF);

    // two pop16 move SP FFF -> 000 -> 001 (wrap)
    op(1'b0, 1'b0, 1'b0, 2'b10, 16'h0, 32'h0, 4'h1);
    next(); next(); idle();
    chk("pop16_wrap_sp", {20'b0, bus.o_SP}, 32'h001);

    // push32 at SP=001 wraps below zero
    op(1'b0, 1'b0, 1'b1, 2'b01, 16'h0, 32'hA5A55A5A, 4'h3);
    next(); next(); idle();
    chk("wrap_memhi", {16'b0, mem[12'h001]}, 32'hA5A5);
    chk("wrap_memlo", {16'b0, mem[12'h000]}, 32'h5A5A);
    chk("wrap_sp",    {20'b0, bus.o_SP}, 32'hFFF);

    // push16 to move SP off its reset value, then push32 aborted by reset in SECOND
    op(1'b0, 1'b0, 1'b0, 2'b01, 16'h0, 32'h00007777, 4'h4);
    next(); idle();
    chk("push16_sp", {20'b0, bus.o_SP}, 32'hFFE);
    op(1'b0, 1'b0, 1'b1, 2'b01, 16'h0, 32'h11112222, 4'h4);
    @(negedge clk);
    chk("abortA_stall", {31'b0, bus.o_Stall}, 32'd1);
    next(); rst = 1'b1;
    @(negedge clk);
    chk("abort_stall", {31'b0, bus.o_Stall}, 32'd0);
    chk("abort_wren",  {31'b0, bus.o_DmWrEn}, 32'd0);
    next(); rst = 1'b0; idle();
    chk("abort_memB", {16'b0, mem[12'hFFD]}, 32'h0000);
    chk("abort_memA", {16'b0, mem[12'hFFE]}, 32'h1111);
    chk("abort_sp",   {20'b0, bus.o_SP}, 32'hFFF);

    // invalid instruction with a write request
    bus.i_MemWrite = 1; bus.i_Addr = 16'h0030; bus.i_WrData = 32'h9999; bus.i_WB = 4'h7;
    @(negedge clk);
    chk("inv_wren", {31'b0, bus.o_DmWrEn}, 32'd0);
    chk("inv_wb",   {28'b0, bus.o_WB}, 32'h0);
    next(); idle();
    chk("inv_sp",  {20'b0, bus.o_SP}, 32'hFFF);
    chk("inv_mem", {16'b0, mem[12'h030]}, 32'h0000);

    // 32-bit store / load at 0x020
    op(1'b0, 1'b1, 1'b1, 2'b00, 16'h0020, 32'hCAFEF00D, 4'h8);
    @(negedge clk);
    chk("st32A_addr",  {20'b0, bus.o_DmAddr}, 32'h020);
    chk("st32A_wdata", {16'b0, bus.o_DmWrData}, 32'hF00D);
    next();
    @(negedge clk);
    chk("st32B_addr",  {20'b0, bus.o_DmAddr}, 32'h021);
    chk("st32B_wdata", {16'b0, bus.o_DmWrData}, 32'hCAFE);
    next();
    op(1'b1, 1'b0, 1'b1, 2'b00, 16'h0020, 32'h0, 4'h9);
    @(negedge clk);
    chk("ld32A_stall", {31'b0, bus.o_Stall}, 32'd1);
    chk("ld32A_data",  bus.o_MemData, 32'h0);
    next();
    @(negedge clk);
    chk("ld32B_data", bus.o_MemData, 32'hCAFEF00D);
    chk("ld32B_wb",   {28'b0, bus.o_WB}, 32'h9);
    next(); idle();
    chk("ld32_sp", {20'b0, bus.o_SP}, 32'hFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
